traffic_phase_scheduler: RTL and testbench

Phase scheduler for a two-road intersection with a pedestrian crossing. It arbitrates main-road, side-road and pedestrian requests and sequences the light phases with per-phase dwell times counted in seconds from an internal prescaler. Its `main_rgy`, `side_rgy` and `ped_walk` outputs drive the light outputs of the traffic-light top level.

---
 rtl/traffic_phase_scheduler.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_traffic_phase_scheduler.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_scheduler.sv
// -----------------------------------------------------------------------------
// traffic_phase_scheduler
//
// Purpose:
//   Phase scheduler for a two-road intersection with a pedestrian crossing.
//   Arbitrates main-road, side-road and pedestrian requests and sequences the
//   light phases. Each phase dwell is counted in whole seconds derived from an
//   internal prescaler. The prescaler and the seconds counter restart on every
//   phase change, so a dwell of N seconds lasts exactly N*CLK_FREQ cycles.
//
// Optional feature:
//   NIGHT_FLASH_EN - when defined, the `night` input forces the controller
//   out of MAIN_GREEN into a flashing-yellow NIGHT phase. When undefined,
//   `night` is ignored and NIGHT can never be reached.
//
// Parameters:
//   CLK_FREQ     clock cycles per second
//   GREEN_MIN_S  minimum green dwell, both roads (s)
//   GREEN_MAX_S  maximum side-road green dwell (s)
//   YELLOW_S     yellow dwell (s)
//   ALL_RED_S    all-red clearance dwell (s)
//   PED_WALK_S   pedestrian walk dwell (s)
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-high
//   side_req     side-road vehicle sensor (level)
//   ped_req      pedestrian button (any-length pulse)
//   night        night-mode request (level, NIGHT_FLASH_EN only)
//   main_rgy     main-road lamps {red, yellow, green}
//   side_rgy     side-road lamps {red, yellow, green}
//   ped_walk     pedestrian walk lamp
//   phase        current state code
//   ped_pending  pedestrian request latched and not yet served
// -----------------------------------------------------------------------------
module traffic_phase_scheduler #(
    parameter int unsigned CLK_FREQ    = 1_000_000,
    parameter int unsigned GREEN_MIN_S = 5,
    parameter int unsigned GREEN_MAX_S = 20,
    parameter int unsigned YELLOW_S    = 3,
    parameter int unsigned ALL_RED_S   = 1,
    parameter int unsigned PED_WALK_S  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       side_req,
    input  logic       ped_req,
    input  logic       night,
    output logic [2:0] main_rgy,
    output logic [2:0] side_rgy,
    output logic       ped_walk,
    output logic [2:0] phase,
    output logic       ped_pending
);

    typedef enum logic [2:0] {
        ST_ALL_RED     = 3'd0,
        ST_MAIN_GREEN  = 3'd1,
        ST_MAIN_YELLOW = 3'd2,
        ST_SIDE_GREEN  = 3'd3,
        ST_SIDE_YELLOW = 3'd4,
        ST_PED_WALK    = 3'd5,
        ST_NIGHT       = 3'd6
    } state_t;

    // A one-cycle-per-second build still needs a 1-bit prescaler.
    localparam int unsigned PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;

    localparam logic [PW-1:0] PRESC_LAST   = PW'(CLK_FREQ - 1);
    localparam logic [7:0]    SEC_MAX      = 8'd255;
    localparam logic [7:0]    ALL_RED_LAST = 8'(ALL_RED_S - 1);
    localparam logic [7:0]    YELLOW_LAST  = 8'(YELLOW_S - 1);
    localparam logic [7:0]    WALK_LAST    = 8'(PED_WALK_S - 1);
    // Green limits are compared against sec+1, which needs 9 bits at 255.
    localparam logic [8:0]    GMIN_W       = 9'(GREEN_MIN_S);
    localparam logic [8:0]    GMAX_W       = 9'(GREEN_MAX_S);

    localparam logic [2:0]    LAMP_R       = 3'b100;
    localparam logic [2:0]    LAMP_Y       = 3'b010;
    localparam logic [2:0]    LAMP_G       = 3'b001;

    // Lamp decode {main_rgy, side_rgy, ped_walk} for a given state.
    function automatic logic [6:0] lamp_decode(input state_t s, input logic blink);
        logic [6:0] l;
        case (s)
            ST_ALL_RED:     l = {LAMP_R, LAMP_R, 1'b0};
            ST_MAIN_GREEN:  l = {LAMP_G, LAMP_R, 1'b0};
            ST_MAIN_YELLOW: l = {LAMP_Y, LAMP_R, 1'b0};
            ST_SIDE_GREEN:  l = {LAMP_R, LAMP_G, 1'b0};
            ST_SIDE_YELLOW: l = {LAMP_R, LAMP_Y, 1'b0};
            ST_PED_WALK:    l = {LAMP_R, LAMP_R, 1'b1};
            ST_NIGHT:       l = {1'b0, blink, 1'b0, 1'b0, blink, 1'b0, 1'b0};
            default:        l = {LAMP_R, LAMP_R, 1'b0};
        endcase
        return l;
    endfunction

    state_t        state_q, state_d;
    state_t        nxt_q, nxt_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    sec_q, sec_d;
    logic          side_pend_q, side_pend_d;
    logic          ped_pend_q, ped_pend_d;
    logic          blink_q, blink_d;
    logic [2:0]    main_rgy_q, main_rgy_d;
    logic [2:0]    side_rgy_q, side_rgy_d;
    logic          ped_walk_q, ped_walk_d;

    logic          tick_s;
    logic [8:0]    sec_inc_s;
    logic          change_s;
    logic          night_go_s;
    logic          night_route_s;

`ifdef NIGHT_FLASH_EN
    // Night request is honoured; a pending NIGHT target survives MAIN_YELLOW.
    assign night_go_s    = night;
    assign night_route_s = (nxt_q == ST_NIGHT);
`else
    logic night_unused_s;
    assign night_unused_s = night;
    assign night_go_s     = 1'b0;
    assign night_route_s  = 1'b0;
`endif

    assign tick_s    = (presc_q == PRESC_LAST);
    assign sec_inc_s = {1'b0, sec_q} + 9'd1;

    // Next-state and follow-on phase selection.
    always_comb begin
        state_d = state_q;
        nxt_d   = nxt_q;
        case (state_q)
            ST_ALL_RED: begin
                if (tick_s && (sec_q == ALL_RED_LAST)) begin
                    state_d = nxt_q;
                end else begin
                    state_d = ST_ALL_RED;
                end
            end
            ST_MAIN_GREEN: begin
                // Night mode skips the minimum-green requirement.
                if (night_go_s) begin
                    state_d = ST_MAIN_YELLOW;
                    nxt_d   = ST_NIGHT;
                end else if (tick_s && (sec_inc_s >= GMIN_W) && (side_pend_q || ped_pend_q)) begin
                    state_d = ST_MAIN_YELLOW;
                end else begin
                    state_d = ST_MAIN_GREEN;
                end
            end
            ST_MAIN_YELLOW: begin
                if (tick_s && (sec_q == YELLOW_LAST)) begin
                    state_d = ST_ALL_RED;
                    if (night_route_s) begin
                        nxt_d = ST_NIGHT;
                    end else if (side_pend_q) begin
                        nxt_d = ST_SIDE_GREEN;
                    end else begin
                        nxt_d = ST_PED_WALK;
                    end
                end else begin
                    state_d = ST_MAIN_YELLOW;
                end
            end
            ST_SIDE_GREEN: begin
                // Max-out wins regardless of the sensor; otherwise release once
                // the road is empty and minimum green has been served.
                if (tick_s && ((sec_inc_s == GMAX_W) ||
                               ((sec_inc_s >= GMIN_W) && !side_req))) begin
                    state_d = ST_SIDE_YELLOW;
                end else begin
                    state_d = ST_SIDE_GREEN;
                end
            end
            ST_SIDE_YELLOW: begin
                if (tick_s && (sec_q == YELLOW_LAST)) begin
                    state_d = ST_ALL_RED;
                    if (ped_pend_q) begin
                        nxt_d = ST_PED_WALK;
                    end else begin
                        nxt_d = ST_MAIN_GREEN;
                    end
                end else begin
                    state_d = ST_SIDE_YELLOW;
                end
            end
            ST_PED_WALK: begin
                if (tick_s && (sec_q == WALK_LAST)) begin
                    state_d = ST_ALL_RED;
                    nxt_d   = ST_MAIN_GREEN;
                end else begin
                    state_d = ST_PED_WALK;
                end
            end
            ST_NIGHT: begin
                if (!night_go_s) begin
                    state_d = ST_ALL_RED;
                    nxt_d   = ST_MAIN_GREEN;
                end else begin
                    state_d = ST_NIGHT;
                end
            end
            default: begin
                // Illegal code: fall back to the safe all-red phase.
                state_d = ST_ALL_RED;
                nxt_d   = ST_MAIN_GREEN;
            end
        endcase
    end

    // Prescaler, seconds counter and night blink flag; all restart on a phase change.
    always_comb begin
        change_s = (state_d != state_q);
        presc_d  = presc_q;
        sec_d    = sec_q;
        blink_d  = blink_q;
        if (change_s) begin
            presc_d = '0;
            sec_d   = 8'd0;
        end else if (tick_s) begin
            presc_d = '0;
            if (sec_q != SEC_MAX) begin
                sec_d = sec_q + 8'd1;
            end else begin
                sec_d = sec_q;
            end
        end else begin
            presc_d = presc_q + PW'(1);
        end
        if (change_s && (state_d == ST_NIGHT)) begin
            blink_d = 1'b1;
        end else if ((state_q == ST_NIGHT) && tick_s) begin
            blink_d = ~blink_q;
        end else begin
            blink_d = blink_q;
        end
    end

    // Request latches: clearing on entry to the serving phase beats a same-cycle set.
    always_comb begin
        side_pend_d = side_pend_q;
        ped_pend_d  = ped_pend_q;
        if ((state_d == ST_SIDE_GREEN) && (state_q != ST_SIDE_GREEN)) begin
            side_pend_d = 1'b0;
        end else if (side_req && (state_q != ST_SIDE_GREEN)) begin
            side_pend_d = 1'b1;
        end else begin
            side_pend_d = side_pend_q;
        end
        if ((state_d == ST_PED_WALK) && (state_q != ST_PED_WALK)) begin
            ped_pend_d = 1'b0;
        end else if (ped_req && (state_q != ST_PED_WALK)) begin
            ped_pend_d = 1'b1;
        end else begin
            ped_pend_d = ped_pend_q;
        end
    end

    // Lamp outputs decoded from the next state so the registered lamps track state_q.
    always_comb begin
        {main_rgy_d, side_rgy_d, ped_walk_d} = lamp_decode(state_d, blink_d);
    end

    // State, timers, latches and registered lamp outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ALL_RED;
            nxt_q       <= ST_MAIN_GREEN;
            presc_q     <= '0;
            sec_q       <= 8'd0;
            side_pend_q <= 1'b0;
            ped_pend_q  <= 1'b0;
            blink_q     <= 1'b0;
            main_rgy_q  <= LAMP_R;
            side_rgy_q  <= LAMP_R;
            ped_walk_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            nxt_q       <= nxt_d;
            presc_q     <= presc_d;
            sec_q       <= sec_d;
            side_pend_q <= side_pend_d;
            ped_pend_q  <= ped_pend_d;
            blink_q     <= blink_d;
            main_rgy_q  <= main_rgy_d;
            side_rgy_q  <= side_rgy_d;
            ped_walk_q  <= ped_walk_d;
        end
    end

    assign main_rgy    = main_rgy_q;
    assign side_rgy    = side_rgy_q;
    assign ped_walk    = ped_walk_q;
    assign phase       = state_q;
    assign ped_pending = ped_pend_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// -----------------------------------------------------------------------------
// tb_traffic_phase_scheduler
//
// Directed bench for traffic_phase_scheduler with CLK_FREQ=4, GREEN_MIN_S=3,
// GREEN_MAX_S=6, YELLOW_S=2, ALL_RED_S=1, PED_WALK_S=4, so one second is four
// cycles. Scenarios run back to back from one initial block; each task drives
// its stimulus and compares against hand-computed phase lengths and lamps.
// -----------------------------------------------------------------------------
module tb_traffic_phase_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       side_req;
    logic       ped_req;
    logic       night;
    logic [2:0] main_rgy;
    logic [2:0] side_rgy;
    logic       ped_walk;
    logic [2:0] phase;
    logic       ped_pending;

    int errors    = 0;
    int checks    = 0;
    int conflicts = 0;

    localparam logic [2:0] R   = 3'b100;
    localparam logic [2:0] Y   = 3'b010;
    localparam logic [2:0] G   = 3'b001;
    localparam logic [2:0] OFF = 3'b000;

    localparam logic [2:0] P_AR = 3'd0;
    localparam logic [2:0] P_MG = 3'd1;
    localparam logic [2:0] P_MY = 3'd2;
    localparam logic [2:0] P_SG = 3'd3;
    localparam logic [2:0] P_SY = 3'd4;
    localparam logic [2:0] P_PW = 3'd5;
    localparam logic [2:0] P_NT = 3'd6;

    always #5 clk = ~clk;

    traffic_phase_scheduler #(
        .CLK_FREQ   (4),
        .GREEN_MIN_S(3),
        .GREEN_MAX_S(6),
        .YELLOW_S   (2),
        .ALL_RED_S  (1),
        .PED_WALK_S (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .side_req   (side_req),
        .ped_req    (ped_req),
        .night      (night),
        .main_rgy   (main_rgy),
        .side_rgy   (side_rgy),
        .ped_walk   (ped_walk),
        .phase      (phase),
        .ped_pending(ped_pending)
    );

    // Conflicting greens (both roads, or a road with walk) must never appear.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if ((main_rgy[0] && side_rgy[0]) || (ped_walk && (main_rgy[0] || side_rgy[0])))
                conflicts++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called on the first observation of a phase; returns its length in cycles.
    task automatic measure(input logic [2:0] ph, output int n);
        n = 0;
        while ((phase === ph) && (n < 3000)) begin
            step();
            n++;
        end
    endtask

    task automatic wait_phase(input logic [2:0] ph, output bit ok);
        int k = 0;
        while ((phase !== ph) && (k < 500)) begin
            step();
            k++;
        end
        ok = (phase === ph);
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1; side_req = 1'b0; ped_req = 1'b1; night = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({main_rgy, side_rgy, ped_walk, phase, ped_pending} !== {R, R, 1'b0, P_AR, 1'b0}) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: got %b want %b", i,
                         {main_rgy, side_rgy, ped_walk, phase, ped_pending}, {R, R, 1'b0, P_AR, 1'b0});
            end
        end
        ped_req = 1'b0;
        rst = 1'b0;
        measure(P_AR, n);
        checks++;
        if (n !== 4) begin errors++; $display("FAIL reset_all_red_len: got %0d want 4", n); end
        checks++;
        if ({phase, main_rgy, side_rgy, ped_walk} !== {P_MG, G, R, 1'b0}) begin
            errors++;
            $display("FAIL reset_main_green: got %b want %b", {phase, main_rgy, side_rgy, ped_walk}, {P_MG, G, R, 1'b0});
        end
    endtask

    task automatic test_side_road();
        int n;
        side_req = 1'b1;
        measure(P_MG, n);
        checks++; if (n !== 12) begin errors++; $display("FAIL side_mg_len: got %0d want 12", n); end
        checks++;
        if ({phase, main_rgy, side_rgy} !== {P_MY, Y, R}) begin
            errors++; $display("FAIL side_my_lamps: got %b want %b", {phase, main_rgy, side_rgy}, {P_MY, Y, R});
        end
        measure(P_MY, n);
        checks++; if (n !== 8) begin errors++; $display("FAIL side_my_len: got %0d want 8", n); end
        measure(P_AR, n);
        checks++; if (n !== 4) begin errors++; $display("FAIL side_ar1_len: got %0d want 4", n); end
        checks++;
        if ({phase, main_rgy, side_rgy, ped_walk} !== {P_SG, R, G, 1'b0}) begin
            errors++; $display("FAIL side_sg_lamps: got %b want %b", {phase, main_rgy, side_rgy, ped_walk}, {P_SG, R, G, 1'b0});
        end
        measure(P_SG, n);
        checks++; if (n !== 24) begin errors++; $display("FAIL side_sg_maxout_len: got %0d want 24", n); end
        checks++;
        if ({phase, main_rgy, side_rgy} !== {P_SY, R, Y}) begin
            errors++; $display("FAIL side_sy_lamps: got %b want %b", {phase, main_rgy, side_rgy}, {P_SY, R, Y});
        end
        measure(P_SY, n);
        checks++; if (n !== 8) begin errors++; $display("FAIL side_sy_len: got %0d want 8", n); end
        measure(P_AR, n);
        checks++; if (n !== 4) begin errors++; $display("FAIL side_ar2_len: got %0d want 4", n); end
        checks++; if (phase !== P_MG) begin errors++; $display("FAIL side_back_to_main: got %0d want %0d", phase, P_MG); end
        // side_req still high: the latch re-armed, so main green ends at minimum.
        measure(P_MG, n);
        checks++; if (n !== 12) begin errors++; $display("FAIL side_relatch_mg_len: got %0d want 12", n); end
        measure(P_MY, n);
        checks++; if (n !== 8) begin errors++; $display("FAIL side_relatch_my_len: got %0d want 8", n); end
        measure(P_AR, n);
        checks++; if (phase !== P_SG) begin errors++; $display("FAIL side_relatch_sg: got %0d want %0d", phase, P_SG); end
    endtask

    task automatic test_pedestrian();
        int n;
        side_req = 1'b0;
        ped_req  = 1'b1;
        step();
        ped_req = 1'b0;
        checks++; if (ped_pending !== 1'b1) begin errors++; $display("FAIL ped_latch: got %b want 1", ped_pending); end
        measure(P_SG, n);
        checks++; if (n !== 11) begin errors++; $display("FAIL ped_sg_gapout_len: got %0d want 11", n); end
        measure(P_SY, n);
        checks++; if (n !== 8) begin errors++; $display("FAIL ped_sy_len: got %0d want 8", n); end
        measure(P_AR, n);
        checks++; if (n !== 4) begin errors++; $display("FAIL ped_ar1_len: got %0d want 4", n); end
        checks++;
        if ({phase, main_rgy, side_rgy, ped_walk, ped_pending} !== {P_PW, R, R, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL ped_walk_entry: got %b want %b", {phase, main_rgy, side_rgy, ped_walk, ped_pending}, {P_PW, R, R, 1'b1, 1'b0});
        end
        measure(P_PW, n);
        checks++; if (n !== 16) begin errors++; $display("FAIL ped_walk_len: got %0d want 16", n); end
        measure(P_AR, n);
        checks++; if (n !== 4) begin errors++; $display("FAIL ped_ar2_len: got %0d want 4", n); end
        checks++;
        if ({phase, main_rgy, side_rgy, ped_walk} !== {P_MG, G, R, 1'b0}) begin
            errors++; $display("FAIL ped_back_to_main: got %b want %b", {phase, main_rgy, side_rgy, ped_walk}, {P_MG, G, R, 1'b0});
        end
    endtask

    task automatic test_idle();
        int bad = 0;
        for (int i = 0; i < 2000; i++) begin
            step();
            if (phase !== P_MG) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL idle_hold: got %0d bad cycles want 0", bad); end
        checks++;
        if ({main_rgy, side_rgy, ped_walk} !== {G, R, 1'b0}) begin
            errors++; $display("FAIL idle_lamps: got %b want %b", {main_rgy, side_rgy, ped_walk}, {G, R, 1'b0});
        end
    endtask

    task automatic test_mid_reset();
        int n;
        bit ok;
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        checks++; if (ped_pending !== 1'b1) begin errors++; $display("FAIL midrst_latch: got %b want 1", ped_pending); end
        wait_phase(P_PW, ok);
        checks++; if (!ok) begin errors++; $display("FAIL midrst_reach_walk: got phase %0d want %0d", phase, P_PW); end
        for (int i = 0; i < 4; i++) step();
        checks++; if (ped_walk !== 1'b1) begin errors++; $display("FAIL midrst_walk_cycle5: got %b want 1", ped_walk); end
        ped_req = 1'b1;
        rst = 1'b1;
        step();
        ped_req = 1'b0;
        checks++;
        if ({main_rgy, side_rgy, ped_walk, phase, ped_pending} !== {R, R, 1'b0, P_AR, 1'b0}) begin
            errors++;
            $display("FAIL midrst_outputs: got %b want %b", {main_rgy, side_rgy, ped_walk, phase, ped_pending}, {R, R, 1'b0, P_AR, 1'b0});
        end
        rst = 1'b0;
        measure(P_AR, n);
        checks++; if (n !== 4) begin errors++; $display("FAIL midrst_all_red_len: got %0d want 4", n); end
        checks++; if (phase !== P_MG) begin errors++; $display("FAIL midrst_restart: got %0d want %0d", phase, P_MG); end
    endtask

`ifdef NIGHT_FLASH_EN
    task automatic test_night();
        int n;
        int on_n = 0;
        int off_n = 0;
        step();
        night = 1'b1;
        step();
        checks++; if (phase !== P_MY) begin errors++; $display("FAIL night_immediate_yellow: got %0d want %0d", phase, P_MY); end
        measure(P_MY, n);
        checks++; if (n !== 8) begin errors++; $display("FAIL night_my_len: got %0d want 8", n); end
        measure(P_AR, n);
        checks++; if (n !== 4) begin errors++; $display("FAIL night_ar_len: got %0d want 4", n); end
        checks++;
        if ({phase, main_rgy, side_rgy, ped_walk} !== {P_NT, Y, Y, 1'b0}) begin
            errors++; $display("FAIL night_entry: got %b want %b", {phase, main_rgy, side_rgy, ped_walk}, {P_NT, Y, Y, 1'b0});
        end
        while ((phase === P_NT) && (main_rgy === Y) && (side_rgy === Y) && (on_n < 20)) begin step(); on_n++; end
        checks++; if (on_n !== 4) begin errors++; $display("FAIL night_on_len: got %0d want 4", on_n); end
        while ((phase === P_NT) && (main_rgy === OFF) && (side_rgy === OFF) && (off_n < 20)) begin step(); off_n++; end
        checks++; if (off_n !== 4) begin errors++; $display("FAIL night_off_len: got %0d want 4", off_n); end
        checks++; if (main_rgy !== Y) begin errors++; $display("FAIL night_on_again: got %b want %b", main_rgy, Y); end
        night = 1'b0;
        step();
        checks++; if (phase !== P_AR) begin errors++; $display("FAIL night_exit: got %0d want %0d", phase, P_AR); end
        measure(P_AR, n);
        checks++; if (n !== 4) begin errors++; $display("FAIL night_exit_ar_len: got %0d want 4", n); end
        checks++; if (phase !== P_MG) begin errors++; $display("FAIL night_to_main: got %0d want %0d", phase, P_MG); end
    endtask
`else
    task automatic test_night();
        int bad = 0;
        step();
        night = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if ((phase !== P_MG) || (main_rgy !== G)) bad++;
        end
        night = 1'b0;
        checks++; if (bad !== 0) begin errors++; $display("FAIL night_ignored: got %0d bad cycles want 0", bad); end
    endtask
`endif

    task automatic test_conflict();
        checks++;
        if (conflicts !== 0) begin errors++; $display("FAIL no_conflict: got %0d conflicting cycles want 0", conflicts); end
    endtask

    initial begin
        rst = 1'b1; side_req = 1'b0; ped_req = 1'b0; night = 1'b0;
        test_reset();
        test_side_road();
        test_pedestrian();
        test_idle();
        test_mid_reset();
        test_night();
        test_conflict();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
